// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - MSB-first serial transmitter for a TLC5615-class SPI DAC channel
// Define DAC_TX_DOUBLE_BUF_EN to add a one-entry holding register so samples can be accepted mid-frame.
module dac_serial_tx #(
   parameter int DATA_W     = 8,
   parameter int FRAME_W    = 16,
   parameter int LEAD_BITS  = 4,
   parameter int CLK_DIV    = 25,
   parameter int CS_HIGH_HP = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              DAC_clk,
   output logic              CS,
   output logic              DAC_din,
   output logic              busy,
   output logic              done
);

   localparam int TRAIL_BITS = FRAME_W - LEAD_BITS - DATA_W;
   localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W      = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int HP_W       = (CS_HIGH_HP > 1) ? $clog2(CS_HIGH_HP) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
   localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(CS_HIGH_HP - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      HOLD     = 2'd3
   } txState;

   txState             state;
   txState             stateNext;
   logic [DIV_W-1:0]   divCnt;
   logic [DIV_W-1:0]   divNext;
   logic [BIT_W-1:0]   bitCnt;
   logic [BIT_W-1:0]   bitNext;
   logic [HP_W-1:0]    hpCnt;
   logic [HP_W-1:0]    hpNext;
   logic [FRAME_W-1:0] shiftReg;
   logic [FRAME_W-1:0] shiftNext;
   logic               doneNext;
   logic               readyNext;
   logic               shifting;
   logic               tick;
   logic               accept;

`ifdef DAC_TX_DOUBLE_BUF_EN
   logic              holdFull;
   logic              holdFullNext;
   logic [DATA_W-1:0] holdData;
`endif

   function automatic logic [FRAME_W-1:0] buildFrame(input logic [DATA_W-1:0] s);
      logic [FRAME_W-1:0] f;
      f = '0;
      f[DATA_W-1:0] = s;
      return f << TRAIL_BITS;
   endfunction

   assign tick   = (divCnt == DIV_LAST);
   assign accept = sample_valid && sample_ready;

   always_comb begin
      stateNext = state;
      shiftNext = shiftReg;
      bitNext   = bitCnt;
      hpNext    = hpCnt;
      doneNext  = 1'b0;
`ifdef DAC_TX_DOUBLE_BUF_EN
      holdFullNext = holdFull;
`endif
      case (state)
         IDLE: begin
            bitNext = '0;
            hpNext  = '0;
`ifdef DAC_TX_DOUBLE_BUF_EN
            // A sample parked during the previous frame has priority; ready is low while it waits.
            if (holdFull) begin
               stateNext    = SHIFT_LO;
               shiftNext    = buildFrame(holdData);
               holdFullNext = 1'b0;
            end else if (accept) begin
               stateNext = SHIFT_LO;
               shiftNext = buildFrame(sample_in);
            end
`else
            if (accept) begin
               stateNext = SHIFT_LO;
               shiftNext = buildFrame(sample_in);
            end
`endif
         end
         SHIFT_LO: begin
            if (tick) stateNext = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (tick) begin
               if (bitCnt == BIT_LAST) begin
                  stateNext = HOLD;
               end else begin
                  bitNext   = bitCnt + 1'b1;
                  shiftNext = {shiftReg[FRAME_W-2:0], 1'b0};
                  stateNext = SHIFT_LO;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               if (hpCnt == HP_LAST) begin
                  stateNext = IDLE;
                  doneNext  = 1'b1;
               end else begin
                  hpNext = hpCnt + 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase

`ifdef DAC_TX_DOUBLE_BUF_EN
      if (accept && (state != IDLE)) holdFullNext = 1'b1;
      readyNext = !holdFullNext;
`else
      readyNext = (stateNext == IDLE);
`endif

      // Divider restarts on every state entry so each half-period is exactly CLK_DIV cycles.
      if ((state == IDLE) || (stateNext != state) || tick) divNext = '0;
      else                                                  divNext = divCnt + 1'b1;

      shifting = (stateNext == SHIFT_LO) || (stateNext == SHIFT_HI);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         divCnt       <= '0;
         bitCnt       <= '0;
         hpCnt        <= '0;
         shiftReg     <= '0;
         CS           <= 1'b1;
         DAC_clk      <= 1'b0;
         DAC_din      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sample_ready <= 1'b0;
      end else begin
         state        <= stateNext;
         divCnt       <= divNext;
         bitCnt       <= bitNext;
         hpCnt        <= hpNext;
         shiftReg     <= shiftNext;
         CS           <= !shifting;
         DAC_clk      <= (stateNext == SHIFT_HI);
         DAC_din      <= shifting ? shiftNext[FRAME_W-1] : 1'b0;
         busy         <= (stateNext != IDLE);
         done         <= doneNext;
         sample_ready <= readyNext;
      end
   end

`ifdef DAC_TX_DOUBLE_BUF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         holdFull <= 1'b0;
         holdData <= '0;
      end else begin
         holdFull <= holdFullNext;
         if (accept && (state != IDLE)) holdData <= sample_in;
      end
   end
`endif

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - directed bench for dac_serial_tx at CLK_DIV=2 and CLK_DIV=1
// Covers DAC_TX_DOUBLE_BUF_EN when the macro is defined for the build.
module tb_dac_serial_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] sampleIn = 8'h00;
   logic       valid = 1'b0;
   logic       sel = 1'b0;

   logic validA, validB;
   logic readyA, readyB, dacClkA, dacClkB, csA, csB, dinA, dinB, busyA, busyB, doneA, doneB;
   logic mReady, mClk, mCs, mDin, mBusy, mDone;

   int assertCnt = 0;
   int failCnt = 0;
   int acceptCnt = 0;
   int acceptBase;

   logic [15:0] wFrame;
   logic        wReadyAtDone, wOfferReady;
   int          wCsLow, wFirstLow, wLastLow, wDone, wBusyFirst, wBusyLast;
   int          wEdges, wToggles, wReadyHigh, wClkCsHigh;

   logic [15:0] frame1;
   int          tail1, edges1, badCnt;

   always #5 clk = ~clk;

   assign validA = valid && !sel;
   assign validB = valid && sel;
   assign mReady = sel ? readyB  : readyA;
   assign mClk   = sel ? dacClkB : dacClkA;
   assign mCs    = sel ? csB     : csA;
   assign mDin   = sel ? dinB    : dinA;
   assign mBusy  = sel ? busyB   : busyA;
   assign mDone  = sel ? doneB   : doneA;

   dac_serial_tx #(.DATA_W(8), .FRAME_W(16), .LEAD_BITS(4), .CLK_DIV(2), .CS_HIGH_HP(2)) dutA (
      .clk(clk), .reset(reset), .sample_in(sampleIn), .sample_valid(validA),
      .sample_ready(readyA), .DAC_clk(dacClkA), .CS(csA), .DAC_din(dinA),
      .busy(busyA), .done(doneA)
   );

   dac_serial_tx #(.DATA_W(8), .FRAME_W(16), .LEAD_BITS(4), .CLK_DIV(1), .CS_HIGH_HP(2)) dutB (
      .clk(clk), .reset(reset), .sample_in(sampleIn), .sample_valid(validB),
      .sample_ready(readyB), .DAC_clk(dacClkB), .CS(csB), .DAC_din(dinB),
      .busy(busyB), .done(doneB)
   );

   always @(posedge clk) begin
      if ((validA && readyA) || (validB && readyB)) acceptCnt++;
   end

   task automatic expectEq(input string tag, input int got, input int exp);
      assertCnt++;
      if (got !== exp) begin
         failCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic startSample(input logic [7:0] s);
      int n;
      n = 0;
      @(negedge clk);
      while (!mReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      expectEq("ready_before_send", 32'(mReady), 1);
      sampleIn = s;
      valid    = 1'b1;
   endtask

   // Observes one frame from the accept edge; cycle numbers count from 1 after that edge.
   task automatic watchFrame(input int limit, input bit holdValid, input bit chain,
                             input logic [7:0] chainData, input int offerAt, input logic [7:0] offerData);
      logic prevClk;
      prevClk = 1'b0;
      wFrame = '0; wCsLow = 0; wFirstLow = 0; wLastLow = 0; wDone = 0; wBusyFirst = 0;
      wBusyLast = 0; wEdges = 0; wToggles = 0; wReadyHigh = 0; wClkCsHigh = 0;
      wReadyAtDone = 1'b0; wOfferReady = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         @(negedge clk);
         if (!holdValid) valid = 1'b0;
         if (cyc == offerAt) begin
            valid       = 1'b1;
            sampleIn    = offerData;
            wOfferReady = mReady;
         end
         if (!mCs) begin
            if (wFirstLow == 0) wFirstLow = cyc;
            else if (mClk != prevClk) wToggles++;
            wLastLow = cyc;
            wCsLow++;
         end else if (mClk) begin
            wClkCsHigh++;
         end
         if (mClk && !prevClk) begin
            wEdges++;
            wFrame = {wFrame[14:0], mDin};
         end
         if (mBusy) begin
            if (wBusyFirst == 0) wBusyFirst = cyc;
            wBusyLast = cyc;
         end
         prevClk = mClk;
         if (mDone) begin
            wDone        = cyc;
            wReadyAtDone = mReady;
            if (chain) begin
               valid    = 1'b1;
               sampleIn = chainData;
            end
            break;
         end
         if (mReady) wReadyHigh++;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      expectEq("rst_cs", 32'(csA), 1);
      expectEq("rst_dac_clk", 32'(dacClkA), 0);
      expectEq("rst_din", 32'(dinA), 0);
      expectEq("rst_busy", 32'(busyA), 0);
      expectEq("rst_done", 32'(doneA), 0);
      expectEq("rst_ready", 32'(readyA), 0);
      reset = 1'b1;
      @(negedge clk);
      expectEq("ready_after_rst_a", 32'(readyA), 1);
      expectEq("ready_after_rst_b", 32'(readyB), 1);

      // Single 0xA5 frame at CLK_DIV=2
      sel = 1'b0;
      startSample(8'hA5);
      acceptBase = acceptCnt;
      watchFrame(200, 1'b0, 1'b0, 8'h00, 0, 8'h00);
      expectEq("a5_frame", 32'(wFrame), 'h0A50);
      expectEq("a5_cs_low_cycles", wCsLow, 64);
      expectEq("a5_cs_first_low", wFirstLow, 1);
      expectEq("a5_cs_last_low", wLastLow, 64);
      expectEq("a5_done_cycle", wDone, 69);
      expectEq("a5_busy_first", wBusyFirst, 1);
      expectEq("a5_busy_last", wBusyLast, 68);
      expectEq("a5_clk_edges", wEdges, 16);
      expectEq("a5_clk_while_cs_high", wClkCsHigh, 0);
      expectEq("a5_accepts", acceptCnt - acceptBase, 1);
`ifdef DAC_TX_DOUBLE_BUF_EN
      expectEq("a5_ready_cycles_in_frame", wReadyHigh, 68);
`else
      expectEq("a5_ready_cycles_in_frame", wReadyHigh, 0);
      expectEq("a5_ready_at_done", 32'(wReadyAtDone), 1);
`endif

      // 0x00 then 0xFF back-to-back, second accepted on the done cycle
      startSample(8'h00);
      watchFrame(200, 1'b0, 1'b1, 8'hFF, 0, 8'h00);
      frame1 = wFrame;
      tail1  = wDone - wLastLow;
      edges1 = wEdges;
      watchFrame(200, 1'b0, 1'b0, 8'h00, 0, 8'h00);
      expectEq("b2b_frame1", 32'(frame1), 'h0000);
      expectEq("b2b_cs_gap", tail1 + wFirstLow - 1, 5);
      expectEq("b2b_frame2", 32'(wFrame), 'h0FF0);
      expectEq("b2b_total_edges", edges1 + wEdges, 32);
      expectEq("b2b_done2_cycle", wDone, 69);

`ifdef DAC_TX_DOUBLE_BUF_EN
      // Second sample offered mid-frame lands in the holding register
      startSample(8'h12);
      acceptBase = acceptCnt;
      watchFrame(200, 1'b0, 1'b0, 8'h00, 10, 8'h5A);
      expectEq("dbuf_offer_ready", 32'(wOfferReady), 1);
      expectEq("dbuf_accepts_frame1", acceptCnt - acceptBase, 2);
      expectEq("dbuf_frame1", 32'(wFrame), 'h0120);
      expectEq("dbuf_done1_cycle", wDone, 69);
      watchFrame(200, 1'b0, 1'b0, 8'h00, 0, 8'h00);
      expectEq("dbuf_cs_fall_after_done", wFirstLow, 1);
      expectEq("dbuf_frame2", 32'(wFrame), 'h05A0);
      expectEq("dbuf_done2_cycle", wDone, 69);
      expectEq("dbuf_accepts_total", acceptCnt - acceptBase, 2);
`else
      // sample_valid held high through the frame
      startSample(8'h3C);
      acceptBase = acceptCnt;
      watchFrame(200, 1'b1, 1'b0, 8'h00, 0, 8'h00);
      expectEq("held_ready_in_frame", wReadyHigh, 0);
      expectEq("held_accepts_frame1", acceptCnt - acceptBase, 1);
      expectEq("held_frame1", 32'(wFrame), 'h03C0);
      watchFrame(200, 1'b0, 1'b0, 8'h00, 0, 8'h00);
      expectEq("held_accepts_frame2", acceptCnt - acceptBase, 2);
      expectEq("held_frame2", 32'(wFrame), 'h03C0);
`endif

      // Reset at cycle 20 of a 0x3C frame
      startSample(8'h3C);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         valid = 1'b0;
      end
      reset = 1'b0;
      @(negedge clk);
      expectEq("midrst_cs", 32'(csA), 1);
      expectEq("midrst_dac_clk", 32'(dacClkA), 0);
      expectEq("midrst_din", 32'(dinA), 0);
      expectEq("midrst_busy", 32'(busyA), 0);
      badCnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (dacClkA || !csA) badCnt++;
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (dacClkA || !csA) badCnt++;
      end
      expectEq("midrst_no_activity", badCnt, 0);
      startSample(8'h81);
      watchFrame(200, 1'b0, 1'b0, 8'h00, 0, 8'h00);
      expectEq("postrst_frame", 32'(wFrame), 'h0810);
      expectEq("postrst_edges", wEdges, 16);
      expectEq("postrst_done_cycle", wDone, 69);

      // CLK_DIV=1 boundary
      sel = 1'b1;
      startSample(8'h01);
      watchFrame(200, 1'b0, 1'b0, 8'h00, 0, 8'h00);
      expectEq("div1_frame", 32'(wFrame), 'h0010);
      expectEq("div1_cs_low_cycles", wCsLow, 32);
      expectEq("div1_cs_last_low", wLastLow, 32);
      expectEq("div1_toggles", wToggles, 31);
      expectEq("div1_edges", wEdges, 16);
      expectEq("div1_done_cycle", wDone, 35);
      expectEq("div1_busy_last", wBusyLast, 34);
      expectEq("div1_clk_while_cs_high", wClkCsHigh, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/dac_serial_tx.md
Name: dac_serial_tx

Overview:
Serial DAC transmitter for the harmonic-injection output path. It is the write-side counterpart of the TLC549 serial ADC readers. It accepts parallel samples over a valid/ready handshake and shifts each one MSB-first to a TLC5615-class SPI DAC on DAC_clk/CS/DAC_din. One instance drives one DAC channel; the three-phase top instantiates three.

Parameters:
DATA_W, 8, sample width (matches ADC sample width)
FRAME_W, 16, total bits per DAC frame
LEAD_BITS, 4, zero bits sent before data; trailing zeros = FRAME_W-LEAD_BITS-DATA_W (must be >=0)
CLK_DIV, 25, system clocks per DAC_clk half-period (>=1)
CS_HIGH_HP, 2, half-periods CS held high after each frame (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
sample_in  in  DATA_W  sample to transmit
sample_valid  in  1  sample_in valid
sample_ready  out  1  block can accept a sample
DAC_clk  out  1  serial clock to DAC, idles low
CS  out  1  DAC chip select, active low
DAC_din  out  1  serial data to DAC
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when a frame (including CS hold) completes

Behaviour:
- Reset (reset==0 at rising clk edge, synchronous, active-low): state=IDLE, CS=1, DAC_clk=0, DAC_din=0, busy=0, done=0, sample_ready=0, divider and bit counter cleared. sample_ready rises on the first cycle after reset deasserts. Reset mid-frame aborts immediately with the same values; the partial frame is discarded.
- Accept: sample_valid && sample_ready at a rising edge. Frame latched as {LEAD_BITS zeros, sample_in, trailing zeros}. sample_valid is ignored when sample_ready=0.
- Divider: counts 0..CLK_DIV-1 and produces a tick on each wrap. It is held at 0 in IDLE and restarts at each state entry.
- FSM:
  IDLE: CS=1, DAC_clk=0, sample_ready=1. On accept go to SHIFT_LO next cycle.
  SHIFT_LO: CS=0, DAC_clk=0, DAC_din=current frame bit (bit FRAME_W-1 first). On tick go to SHIFT_HI.
  SHIFT_HI: DAC_clk=1; DAC samples on this rising edge and DAC_din is stable. On tick: if bit_cnt==FRAME_W-1 go to HOLD, else bit_cnt++, shift, and go to SHIFT_LO.
  HOLD: CS=1, DAC_clk=0, DAC_din=0 for CS_HIGH_HP ticks, then go to IDLE with done=1 for that one cycle.
- DAC_din changes only while DAC_clk is low (on SHIFT_LO entry).
- Timing (accept at edge 0): CS low on cycles 1..2*FRAME_W*CLK_DIV. CS returns high on cycle 2*FRAME_W*CLK_DIV+1. done is asserted on cycle (2*FRAME_W+CS_HIGH_HP)*CLK_DIV+1. sample_ready is high again that same cycle.
- Exactly FRAME_W rising DAC_clk edges per frame; no DAC_clk edges while CS=1.
- Back-to-back: accept is allowed on the done cycle; the next CS falling edge follows one cycle later.
- All outputs are registered; no combinational path from inputs to DAC pins.

Optional Feature:
Macro DAC_TX_DOUBLE_BUF_EN.
- Defined: one-entry holding register. sample_ready = !hold_full, independent of FSM state, so a sample can be accepted mid-frame. If hold_full when entering IDLE, the held sample starts transmitting on the next cycle (SHIFT_LO) and hold_full clears. done still pulses once per frame. Reset clears hold_full.
- Not defined: no buffer; sample_ready is high only in IDLE (behaviour above).

Test Plan:
- CLK_DIV=2, CS_HIGH_HP=2, sample 0xA5 -> DAC_din sampled at 16 DAC_clk rising edges reads 0x0A50 MSB-first; CS low exactly 64 cycles; done asserted on cycle 69 after accept; busy high cycles 1..68.
- Samples 0x00 then 0xFF sent back-to-back, second accepted on the done cycle -> frames 0x0000 and 0x0FF0; CS high gap between frames = 2*CLK_DIV+1 cycles; exactly 32 DAC_clk rising edges total.
- sample_valid held high while busy (macro off) -> exactly one accept per frame; sample_ready=0 from cycle 1 until done.
- reset=0 asserted at cycle 20 of a 0x3C frame -> next cycle CS=1, DAC_clk=0, DAC_din=0, busy=0; no further DAC_clk edges; new sample 0x81 after release sends 0x0810 correctly.
- DAC_TX_DOUBLE_BUF_EN defined, second sample 0x5A offered at cycle 10 of first frame -> accepted at cycle 10; second CS falling edge one cycle after first done; frame 0x05A0.
- CLK_DIV=1 boundary, sample 0x01 -> DAC_clk toggles every cycle; frame 0x0010; CS low 32 cycles.
